// File: rtl/lfsr_arbiter_ctrl.sv
// Two-requester round-robin arbiter streaming LFSR beats in bursts.
// Define LFSR_PERIOD_CHK_EN to build in the sequence-period checker.
module lfsr_arbiter_ctrl #(
    parameter int             W     = 4,
    parameter logic [W-1:0]   TAPS  = 4'b1101,
    parameter int             LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             seed_load,
    input  logic [W-1:0]     seed_val,
    input  logic             ready,
    output logic             grant0,
    output logic             grant1,
    output logic             busy,
    output logic [W-1:0]     data,
    output logic             valid,
    output logic             last,
    output logic [W:0]       period_len,
    output logic             period_hit
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     lfsr;
    logic [W-1:0]     lfsr_step;
    logic [W-1:0]     seed_fix;
    logic             owner;
    logic             last_srv;
    logic             winner;
    logic [LEN_W-1:0] cnt;
    logic             do_load;
    logic             do_grant;
    logic             do_step;
    logic             done;

    assign lfsr_step = {^(lfsr & TAPS), lfsr[W-1:1]};
    // An all-zero seed would lock the register, so substitute 1.
    assign seed_fix  = (seed_val == '0) ? W'(1) : seed_val;
    assign data      = lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_grant  = 1'b0;
        do_step   = 1'b0;
        done      = 1'b0;
        winner    = (req0 && req1) ? ~last_srv : req1;
        busy      = 1'b0;
        valid     = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (seed_load) begin
                    do_load = 1'b1;
                end else if (req0 || req1) begin
                    do_grant  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                valid  = 1'b1;
                grant0 = ~owner;
                grant1 = owner;
                last   = (cnt == '0);
                if (ready) begin
                    do_step = 1'b1;
                    if (cnt == '0) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr     <= W'(1);
            owner    <= 1'b0;
            last_srv <= 1'b1;
            cnt      <= '0;
        end else begin
            if (do_load) begin
                lfsr <= seed_fix;
            end else if (do_step) begin
                lfsr <= lfsr_step;
            end
            if (do_grant) begin
                owner <= winner;
                cnt   <= winner ? len1 : len0;
            end else if (do_step && !done) begin
                cnt <= cnt - 1'b1;
            end
            if (done) begin
                last_srv <= owner;
            end
        end
    end

`ifdef LFSR_PERIOD_CHK_EN
    logic [W-1:0] seed_reg;
    logic [W:0]   steps;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_reg   <= W'(1);
            steps      <= '0;
            period_len <= '0;
            period_hit <= 1'b0;
        end else begin
            period_hit <= 1'b0;
            if (do_load) begin
                seed_reg <= seed_fix;
                steps    <= '0;
            end else if (do_step) begin
                if (lfsr_step == seed_reg) begin
                    period_hit <= 1'b1;
                    period_len <= steps + 1'b1;
                    steps      <= '0;
                end else begin
                    steps <= steps + 1'b1;
                end
            end
        end
    end
`else
    assign period_len = '0;
    assign period_hit = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_arbiter_ctrl.sv
// Bench for lfsr_arbiter_ctrl: directed literal checks plus
// randomized traffic compared against a behavioural model.
module tb_lfsr_arbiter_ctrl;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [3:0] len0, len1;
    logic       seed_load;
    logic [3:0] seed_val;
    logic       ready;
    logic       grant0, grant1, busy, valid, last, period_hit;
    logic [3:0] data;
    logic [4:0] period_len;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 0;

    lfsr_arbiter_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .len0       (len0),
        .len1       (len1),
        .seed_load  (seed_load),
        .seed_val   (seed_val),
        .ready      (ready),
        .grant0     (grant0),
        .grant1     (grant1),
        .busy       (busy),
        .data       (data),
        .valid      (valid),
        .last       (last),
        .period_len (period_len),
        .period_hit (period_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] s);
        return {^(s & 4'b1101), s[3:1]};
    endfunction

    // behavioural model: burst bookkeeping in plain integers
    bit         m_run;
    int         m_owner;
    int         m_lastsrv;
    int         m_rem;
    logic [3:0] m_lfsr;
    logic [3:0] m_seed;
    int         m_steps;
    int         m_plen;
    bit         m_phit;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 0; m_owner = 0; m_lastsrv = 1; m_rem = 0;
            m_lfsr = 4'd1; m_seed = 4'd1;
            m_steps = 0; m_plen = 0; m_phit = 0;
        end else begin
            m_phit = 0;
            if (!m_run) begin
                if (seed_load) begin
                    m_lfsr  = (seed_val == 0) ? 4'd1 : seed_val;
                    m_seed  = m_lfsr;
                    m_steps = 0;
                end else if (req0 || req1) begin
                    if (req0 && req1) m_owner = (m_lastsrv == 1) ? 0 : 1;
                    else m_owner = req1 ? 1 : 0;
                    m_rem = (m_owner == 1) ? int'(len1) + 1 : int'(len0) + 1;
                    m_run = 1;
                end
            end else if (ready) begin
                m_lfsr = nxt(m_lfsr);
                m_steps++;
                if (m_lfsr == m_seed) begin
                    m_phit = 1; m_plen = m_steps; m_steps = 0;
                end
                m_rem--;
                if (m_rem == 0) begin
                    m_run = 0; m_lastsrv = m_owner;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_valid", valid, m_run);
            chk("m_busy", busy, m_run);
            chk("m_grant0", grant0, m_run && m_owner == 0);
            chk("m_grant1", grant1, m_run && m_owner == 1);
            chk("m_last", last, m_run && m_rem == 1);
            chk("m_data", data, m_lfsr);
`ifdef LFSR_PERIOD_CHK_EN
            chk("m_phit", period_hit, m_phit);
            chk("m_plen", period_len, m_plen);
`else
            chk("m_phit", period_hit, 0);
            chk("m_plen", period_len, 0);
`endif
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        req0 = 0; req1 = 0; len0 = 0; len1 = 0;
        seed_load = 0; seed_val = 0; ready = 0;
        @(negedge clk);
        chk("rst_data", data, 1);
        chk("rst_outs", {grant0, grant1, valid, busy, last}, 0);
        chk("rst_per", {period_len, period_hit}, 0);
        reset = 1'b0;
    endtask

    int exp21 [7] = '{1, 8, 12, 6, 11, 5, 2};
    bit g0e [9] = '{1, 1, 0, 0, 0, 0, 1, 1, 0};
    bit g1e [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};

    initial begin
        reset = 0; req0 = 0; req1 = 0; len0 = 0; len1 = 0;
        seed_load = 0; seed_val = 0; ready = 0;
        #1 reset = 1'b1;
        @(negedge clk);
        cmp_on = 1;
        reset = 1'b0;

        // single burst from requester 0
        do_reset();
        req0 = 1; len0 = 6; ready = 1;
        @(negedge clk);
        chk("b21_grant0", grant0, 1);
        req0 = 0;
        for (int b = 0; b < 7; b++) begin
            chk("b21_data", data, exp21[b]);
            chk("b21_last", last, b == 6);
            @(negedge clk);
        end
        chk("b21_end_valid", valid, 0);

        // round-robin with back-to-back requests
        do_reset();
        req0 = 1; req1 = 1; len0 = 1; len1 = 1; ready = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("rr_g0", grant0, g0e[i]);
            chk("rr_g1", grant1, g1e[i]);
        end
        req0 = 0; req1 = 0;

        // ready toggling: four beats over eight cycles
        do_reset();
        req0 = 1; len0 = 3;
        @(negedge clk);
        req0 = 0;
        for (int i = 0; i < 8; i++) begin
            ready = (i % 2 == 0);
            @(negedge clk);
        end
        chk("tog_data", data, 11);
        chk("tog_valid", valid, 0);

        // seed load with a pending request defers the grant
        do_reset();
        seed_load = 1; seed_val = 9;
        @(negedge clk);
        chk("seed9", data, 9);
        seed_val = 0; req1 = 1;
        @(negedge clk);
        seed_load = 0;
        chk("seed0", data, 1);
        chk("seed_g1_early", grant1, 0);
        @(negedge clk);
        chk("seed_g1", grant1, 1);
        req1 = 0; ready = 1;
        repeat (3) @(negedge clk);

        // reset mid-burst
        do_reset();
        req0 = 1; len0 = 5; ready = 1;
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("ab_beat3", data, 12);
        #2 reset = 1'b1;
        #1;
        chk("ab_data", data, 1);
        chk("ab_outs", {grant0, grant1, valid, busy, last}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("ab_novalid", valid, 0);
        end

`ifdef LFSR_PERIOD_CHK_EN
        do_reset();
        req0 = 1; len0 = 13; ready = 1;
        @(negedge clk);
        req0 = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk("per_hit", period_hit, (i == 7 || i == 14));
        end
        chk("per_len", period_len, 7);
`endif

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset     = 1'b0;
            req0      = ($urandom_range(0, 9) < 4);
            req1      = ($urandom_range(0, 9) < 4);
            len0      = 4'($urandom_range(0, 15));
            len1      = 4'($urandom_range(0, 15));
            ready     = ($urandom_range(0, 3) != 0);
            seed_load = ($urandom_range(0, 19) == 0);
            seed_val  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b1;
            end
        end
        @(negedge clk);
        reset = 0; req0 = 0; req1 = 0; seed_load = 0; ready = 1;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
